// File: rtl/tetris_pkg.sv
// Shared piece encoding for the Tetris core.
// Used by the next-piece generator, the game FSM and the renderer.
//   piece_t      : 3-bit piece code, 0 = no piece, 1..7 = I,J,L,O,S,T,Z
//   piece_mask() : one-hot bag bit for a piece (bit p-1), all zero for none
package tetris_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_NONE = 3'd0;
  localparam piece_t PIECE_I    = 3'd1;
  localparam piece_t PIECE_J    = 3'd2;
  localparam piece_t PIECE_L    = 3'd3;
  localparam piece_t PIECE_O    = 3'd4;
  localparam piece_t PIECE_S    = 3'd5;
  localparam piece_t PIECE_T    = 3'd6;
  localparam piece_t PIECE_Z    = 3'd7;

  localparam int NUM_PIECES = 7;

  function automatic logic [NUM_PIECES-1:0] piece_mask(input piece_t p);
    logic [NUM_PIECES-1:0] m;
    m = '0;
    if (p != PIECE_NONE) m[p - 3'd1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shifting Galois LFSR.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset, loads SEED
//   load     : load load_val this edge instead of stepping
//   load_val : value to load (caller guarantees it is nonzero)
//   q        : current LFSR state
module lfsr_galois #(
  parameter int          W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= load_val;
    end else begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/piece_bag_gen.sv
// Next-piece generator: LFSR candidates filtered by uniform or 7-bag rules
// into a PREVIEW+1 deep queue. Slot 0 is the head piece.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   seed_load : reseed the LFSR with seed_in (0 selects SEED)
//   seed_in   : new seed
//   take      : pop the head piece (ignored when the queue is empty)
//   valid     : head piece present
//   piece     : head piece, 0 when empty
//   preview   : slots 1..PREVIEW, slot 1 in the LSBs, 0 for empty slots
module piece_bag_gen
  import tetris_pkg::*;
#(
  parameter int               LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int               PREVIEW  = 3,
  parameter bit               BAG_MODE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_in,
  input  logic                 take,
  output logic                 valid,
  output piece_t               piece,
  output logic [3*PREVIEW-1:0] preview
);

  localparam int DEPTH = PREVIEW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [NUM_PIECES-1:0] BAG_FULL = '1;

  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     load_val;
  logic                  lfsr_unused;
  piece_t                cand;

  piece_t                slot_q [DEPTH];
  piece_t                slot_d [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      fill_idx;
  logic [NUM_PIECES-1:0] used_q, used_d, used_nx;
  logic                  do_take, bag_ok, accept;

  // A zero seed would lock the LFSR, so fall back to SEED.
  assign load_val = (seed_in == '0) ? SEED : seed_in;

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .load_val (load_val),
    .q        (lfsr)
  );

  // Only the low three bits form the candidate.
  assign cand        = piece_t'(lfsr[2:0]);
  assign lfsr_unused = ^lfsr[LFSR_W-1:3];

  always_comb begin
    slot_d   = slot_q;
    used_d   = used_q;
    used_nx  = used_q | piece_mask(cand);
    do_take  = take && (count_q != '0);
    bag_ok   = !BAG_MODE || ((used_q & piece_mask(cand)) == '0);
    accept   = (cand != PIECE_NONE) && ((count_q < DEPTH_C) || do_take) && bag_ok;
    // Write position is the first free slot after any pop this edge.
    fill_idx = do_take ? count_q - 1'b1 : count_q;
    count_d  = accept ? fill_idx + 1'b1 : fill_idx;

    if (do_take) begin
      for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i + 1];
      slot_d[DEPTH - 1] = PIECE_NONE;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (fill_idx == CNT_W'(i))) slot_d[i] = cand;
    end

    // The accept that completes the bag also starts the next one.
    if (BAG_MODE && accept) used_d = (used_nx == BAG_FULL) ? '0 : used_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= PIECE_NONE;
      count_q <= '0;
      used_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      used_q  <= used_d;
    end
  end

  assign valid = (slot_q[0] != PIECE_NONE);
  assign piece = slot_q[0];

  for (genvar g = 0; g < PREVIEW; g++) begin : g_preview
    assign preview[3*g +: 3] = slot_q[g + 1];
  end

endmodule

// File: tb/tb_piece_bag_gen.sv
module tb_piece_bag_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        take_b, take_u;
  logic        valid_b, valid_u;
  logic [2:0]  piece_b, piece_u;
  logic [8:0]  preview_b, preview_u;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  piece_bag_gen #(.BAG_MODE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .take(take_b), .valid(valid_b), .piece(piece_b), .preview(preview_b)
  );

  piece_bag_gen #(.BAG_MODE(1'b0)) dut_u (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .take(take_u), .valid(valid_u), .piece(piece_u), .preview(preview_u)
  );

  // ---------------- behavioural model: queue + bag set + LFSR -------------
  logic [15:0] m_lfsr [2];
  bit   [7:0]  m_seen [2];
  int          mq_b[$];
  int          mq_u[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 16'hACE1;
      m_seen[k] = '0;
    end
    mq_b.delete();
    mq_u.delete();
  endtask

  task automatic model_step(input int k, input bit tk, input bit ld, input logic [15:0] sin);
    int q[$];
    logic [2:0] c;
    if (k == 0) q = mq_b; else q = mq_u;
    c = m_lfsr[k][2:0];
    if (tk && q.size() > 0) void'(q.pop_front());
    if (c != 3'd0 && q.size() < 4 && (k == 1 || !m_seen[k][c])) begin
      q.push_back(int'(c));
      if (k == 0) begin
        m_seen[k][c] = 1'b1;
        if (m_seen[k][7:1] == 7'h7F) m_seen[k] = '0;
      end
    end
    if (ld) m_lfsr[k] = (sin == 16'h0) ? 16'hACE1 : sin;
    else    m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 16'hB400 : 16'h0000);
    if (k == 0) mq_b = q; else mq_u = q;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        model_step(0, take_b, seed_load, seed_in);
        model_step(1, take_u, seed_load, seed_in);
      end
    end
  end

  // ---------------- checking ----------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errs++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic compare_one(input string nm, input int q[$], input logic v,
                             input logic [2:0] p, input logic [8:0] pv);
    logic [8:0] epv;
    epv = '0;
    for (int i = 1; i < 4; i++) if (i < q.size()) epv[3*(i-1) +: 3] = 3'(q[i]);
    chk({nm, "_valid"},   32'(v),  32'(q.size() > 0));
    chk({nm, "_piece"},   32'(p),  (q.size() > 0) ? q[0] : 0);
    chk({nm, "_preview"}, 32'(pv), 32'(epv));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compare_one("mdl_bag", mq_b, valid_b, piece_b, preview_b);
        compare_one("mdl_uni", mq_u, valid_u, piece_u, preview_u);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus --------------------------------------
  logic [15:0] lfsr_exp [6];
  logic [2:0]  c_sim;
  logic [2:0]  pv;
  logic [7:0]  grp;
  int          hist [8];
  int          n, cyc;

  initial begin
    lfsr_exp = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27};
    rst = 1'b1; seed_load = 1'b0; seed_in = '0; take_b = 1'b0; take_u = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_b", 32'(valid_b), 0);
    chk("rst_piece_b", 32'(piece_b), 0);
    chk("rst_prev_b",  32'(preview_b), 0);
    chk("rst_valid_u", 32'(valid_u), 0);
    chk("rst_piece_u", 32'(piece_u), 0);
    chk("rst_prev_u",  32'(preview_u), 0);
    chk_en = 1'b1;

    // Release reset with take held: take on an empty queue is ignored.
    rst = 1'b0; take_b = 1'b1; take_u = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lfsr_seq",   32'(dut_b.u_lfsr.q), 32'(lfsr_exp[k]));
      chk("model_lfsr", 32'(m_lfsr[0]),      32'(lfsr_exp[k]));
      tick();
      if (k == 0) begin
        take_b = 1'b0; take_u = 1'b0;
        chk("first_valid_b", 32'(valid_b), 1);
        chk("first_piece_b", 32'(piece_b), 1);
        chk("first_valid_u", 32'(valid_u), 1);
        chk("first_piece_u", 32'(piece_u), 1);
      end
    end
    chk("fill_piece_b", 32'(piece_b),   1);
    chk("fill_prev_b",  32'(preview_b), 32'h1F4);
    chk("fill_prev_u",  32'(preview_u), 32'h1F4);

    // Full queue holds while the LFSR keeps running.
    repeat (20) tick();
    chk("hold_piece_b", 32'(piece_b),   1);
    chk("hold_prev_b",  32'(preview_b), 32'h1F4);

    // Take on an edge where the bag accepts: count constant, new piece last.
    n = 0;
    while (!(m_lfsr[0][2:0] != 3'd0 && !m_seen[0][m_lfsr[0][2:0]]) && n < 200) begin
      tick();
      n++;
    end
    chk("simul_wait_ok", 32'(n < 200), 1);
    c_sim  = m_lfsr[0][2:0];
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    chk("simul_piece", 32'(piece_b),   4);
    chk("simul_prev",  32'(preview_b), 32'({c_sim, 3'd7, 3'd6}));
    chk("simul_full",  32'(preview_b[8:6] != 3'd0), 1);

    // Reseed with zero selects the default seed; queue untouched.
    seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("seed0_lfsr_b", 32'(dut_b.u_lfsr.q), 32'hACE1);
    chk("seed0_lfsr_u", 32'(dut_u.u_lfsr.q), 32'hACE1);
    chk("seed0_model",  32'(m_lfsr[0]),      32'hACE1);
    chk("seed0_piece",  32'(piece_b),        4);

    seed_load = 1'b1; seed_in = 16'h0001;
    tick();
    seed_load = 1'b0;
    chk("seed1_lfsr_b", 32'(dut_b.u_lfsr.q), 32'h0001);
    chk("seed1_piece",  32'(piece_b),        4);
    chk("seed1_prev1",  32'(preview_b[2:0]), 6);
    tick();
    chk("seed1_step",   32'(dut_b.u_lfsr.q), 32'hB400);

    // Bag mode: 70 pops, one every 10 cycles, groups of 7 are permutations.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grp = '0;
    for (int p = 0; p < 70; p++) begin
      repeat (9) tick();
      pv = piece_b;
      chk("bag_nonzero", 32'(pv != 3'd0), 1);
      grp[pv] = 1'b1;
      take_b = 1'b1;
      tick();
      take_b = 1'b0;
      if (p % 7 == 6) begin
        chk("bag_perm", 32'(grp[7:1]), 32'h7F);
        grp = '0;
      end
    end

    // Uniform mode: 7000 pops, distribution check.
    for (int v = 0; v < 8; v++) hist[v] = 0;
    take_u = 1'b1;
    n = 0; cyc = 0;
    while (n < 7000 && cyc < 30000) begin
      @(negedge clk);
      if (valid_u) begin
        hist[piece_u]++;
        n++;
      end
      cyc++;
    end
    tick();
    take_u = 1'b0;
    chk("uni_pops", 32'(n), 7000);
    chk("uni_zero", 32'(hist[0]), 0);
    for (int v = 1; v < 8; v++) chk_range($sformatf("uni_count_%0d", v), hist[v], 850, 1150);

    // Asynchronous reset mid-cycle with a full queue.
    tick();
    chk("pre_rst_valid", 32'(valid_b), 1);
    chk("pre_rst_full",  32'(preview_b[8:6] != 3'd0), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid_b", 32'(valid_b),   0);
    chk("arst_piece_b", 32'(piece_b),   0);
    chk("arst_prev_b",  32'(preview_b), 0);
    chk("arst_valid_u", 32'(valid_u),   0);
    chk("arst_prev_u",  32'(preview_u), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_piece", 32'(piece_b), 1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
